cnn_layer_sequencer: RTL and testbench

- Parametrised top-level run controller for the CNN accelerator.
- Sequences NUM_LAYERS layers; each layer is a weight-load request followed by a configurable number of tile computations.
- Talks to the layer engine through req/ack and valid/ready handshakes.
- Adds zero-tile layer skip, abort, a watchdog timeout and error reporting.

---
 rtl/cnn_layer_sequencer_pkg.sv | 28 ++
 rtl/cnn_seq_watchdog.sv | 37 +++
 rtl/cnn_layer_sequencer.sv | 166 ++++++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_layer_sequencer_pkg.sv
// Shared state encodings, error codes and width helpers for the CNN layer sequencer.
// Pure definitions: no latency, no flow control.
package cnn_layer_sequencer_pkg;

  localparam int StateLength = 3;

  // Idle/Init keep their historical codes; the calculate phase is split into load/issue/wait.
  typedef enum logic [StateLength-1:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_NEXT  = 3'd5,
    ST_FIN   = 3'd6,
    ST_ERR   = 3'd7
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_ABORT   = 2'd2;
  localparam logic [1:0] ERR_PROTO   = 2'd3;

  function automatic int layer_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_seq_watchdog.sv
// Consecutive-cycle watchdog: expired is combinational on the TIMEOUT-th enabled cycle.
// No backpressure; clear or a low enable restarts the count, TIMEOUT=0 never expires.
module cnn_seq_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic w_unused;
      assign w_unused = ^{clk, rst, clear, enable};
      assign expired  = 1'b0;
    end else begin : g_on
      localparam int W = $clog2(TIMEOUT + 1);
      logic [W-1:0] r_cnt;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_cnt <= '0;
        end else if (clear || !enable) begin
          r_cnt <= '0;
        end else if (r_cnt != W'(TIMEOUT)) begin
          r_cnt <= r_cnt + W'(1);
        end
      end

      // r_cnt counts the enabled cycles already completed, so this fires on the TIMEOUT-th one.
      assign expired = enable && (r_cnt == W'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Run controller: per layer a weight-load req/ack, then tiles via tile_valid/tile_ready and calc_done.
// Outputs decode registered state (no comb paths from inputs); load_req/tile_valid hold until acknowledged.
module cnn_layer_sequencer
  import cnn_layer_sequencer_pkg::*;
#(
  parameter int NUM_LAYERS = 3,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 1024,
  parameter int LAYER_W    = layer_w(NUM_LAYERS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        startFlag,
  input  logic                        abort,
  input  logic [NUM_LAYERS*CNT_W-1:0] tile_cnt_cfg,
  output logic [LAYER_W-1:0]          layer_idx,
  output logic [CNT_W-1:0]            tile_idx,
  output logic                        load_req,
  input  logic                        load_done,
  output logic                        tile_valid,
  input  logic                        tile_ready,
  input  logic                        calc_done,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [1:0]                  err_code
);

  state_e                             r_state;
  state_e                             w_next;
  logic   [LAYER_W-1:0]               r_layer;
  logic   [LAYER_W-1:0]               w_layer_nxt;
  logic   [CNT_W-1:0]                 r_tile;
  logic   [CNT_W-1:0]                 w_tile_nxt;
  logic   [NUM_LAYERS-1:0][CNT_W-1:0] r_tiles;
  logic                               r_err;
  logic                               w_err_nxt;
  logic   [1:0]                       r_err_code;
  logic   [1:0]                       w_err_code_nxt;

  logic   [CNT_W-1:0]                 w_cur_tiles;
  logic                               w_zero_layer;
  logic                               w_last_tile;
  logic                               w_last_layer;
  logic                               w_wd_enable;
  logic                               w_wd_clear;
  logic                               w_wd_expired;

  assign w_cur_tiles  = r_tiles[r_layer];
  assign w_zero_layer = (w_cur_tiles == '0);
  assign w_last_tile  = (r_tile == w_cur_tiles - CNT_W'(1));
  assign w_last_layer = (r_layer == LAYER_W'(NUM_LAYERS - 1));
  assign w_wd_enable  = (r_state == ST_LOAD) || (r_state == ST_ISSUE) || (r_state == ST_WAIT);
  assign w_wd_clear   = (w_next != r_state);

  cnn_seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_wd_clear),
    .enable  (w_wd_enable),
    .expired (w_wd_expired)
  );

  always_comb begin
    w_next         = r_state;
    w_layer_nxt    = r_layer;
    w_tile_nxt     = r_tile;
    w_err_nxt      = r_err;
    w_err_code_nxt = r_err_code;

    if (r_state == ST_IDLE) begin
      if (startFlag) begin
        w_next         = ST_INIT;
        w_layer_nxt    = '0;
        w_tile_nxt     = '0;
        w_err_nxt      = 1'b0;
        w_err_code_nxt = ERR_NONE;
      end
    end else if (r_state == ST_ERR) begin
      w_next = ST_IDLE;
    end else if (abort) begin
      w_next         = ST_ERR;
      w_err_nxt      = 1'b1;
      w_err_code_nxt = ERR_ABORT;
    end else if (w_wd_expired) begin
      w_next         = ST_ERR;
      w_err_nxt      = 1'b1;
      w_err_code_nxt = ERR_TIMEOUT;
    end else if (calc_done && ((r_state == ST_LOAD) || (r_state == ST_ISSUE))) begin
      // A result can only legitimately arrive while a tile is outstanding.
      w_next         = ST_ERR;
      w_err_nxt      = 1'b1;
      w_err_code_nxt = ERR_PROTO;
    end else begin
      case (r_state)
        ST_INIT: w_next = ST_LOAD;
        ST_LOAD: begin
          if (w_zero_layer) begin
            w_next = ST_NEXT;
          end else if (load_done) begin
            w_next = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (tile_ready) begin
            w_next = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (calc_done) begin
            if (w_last_tile) begin
              w_tile_nxt = '0;
              w_next     = ST_NEXT;
            end else begin
              w_tile_nxt = r_tile + CNT_W'(1);
              w_next     = ST_ISSUE;
            end
          end
        end
        ST_NEXT: begin
          if (w_last_layer) begin
            w_next = ST_FIN;
          end else begin
            w_layer_nxt = r_layer + LAYER_W'(1);
            w_next      = ST_LOAD;
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_layer    <= '0;
      r_tile     <= '0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_tiles    <= '0;
    end else begin
      r_state    <= w_next;
      r_layer    <= w_layer_nxt;
      r_tile     <= w_tile_nxt;
      r_err      <= w_err_nxt;
      r_err_code <= w_err_code_nxt;
      if (r_state == ST_INIT) begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
          r_tiles[i] <= tile_cnt_cfg[i*CNT_W +: CNT_W];
        end
      end
    end
  end

  assign layer_idx  = r_layer;
  assign tile_idx   = r_tile;
  assign load_req   = (r_state == ST_LOAD) && !w_zero_layer;
  assign tile_valid = (r_state == ST_ISSUE);
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_FIN);
  assign err        = r_err;
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer: per-cycle vector tables plus hand-written error/reset sequences.
module tb_cnn_layer_sequencer;

  localparam int NL = 3;
  localparam int CW = 16;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          startFlag, abort, load_done, tile_ready, calc_done;
  logic [NL*CW-1:0] tile_cnt_cfg;
  logic [1:0]    layer_idx;
  logic [CW-1:0] tile_idx;
  logic          load_req, tile_valid, busy, done, err;
  logic [1:0]    err_code;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        st, ab, ld, tr, cd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  cnn_layer_sequencer #(
    .NUM_LAYERS (NL),
    .CNT_W      (CW),
    .TIMEOUT    (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .startFlag    (startFlag),
    .abort        (abort),
    .tile_cnt_cfg (tile_cnt_cfg),
    .layer_idx    (layer_idx),
    .tile_idx     (tile_idx),
    .load_req     (load_req),
    .load_done    (load_done),
    .tile_valid   (tile_valid),
    .tile_ready   (tile_ready),
    .calc_done    (calc_done),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .err_code     (err_code)
  );

  function automatic logic [31:0] pk(input logic [1:0] lay, input logic [15:0] til, input logic lrq,
                                     input logic tv, input logic bsy, input logic dn, input logic er,
                                     input logic [1:0] ec);
    return {7'd0, lay, til, lrq, tv, bsy, dn, er, ec};
  endfunction

  function automatic logic [31:0] dut_out();
    return pk(layer_idx, tile_idx, load_req, tile_valid, busy, done, err, err_code);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic ab, input logic ld, input logic tr, input logic cd,
                     input logic [1:0] lay, input logic [15:0] til, input logic lrq, input logic tv,
                     input logic bsy, input logic dn, input logic er, input logic [1:0] ec);
    vec_t v;
    v.st = st; v.ab = ab; v.ld = ld; v.tr = tr; v.cd = cd;
    v.exp = pk(lay, til, lrq, tv, bsy, dn, er, ec);
    tbl.push_back(v);
  endtask

  task automatic zero_inputs();
    startFlag = 0; abort = 0; load_done = 0; tile_ready = 0; calc_done = 0;
  endtask

  // Row 0 is always the IDLE start cycle; from row 2 the config is scrambled to prove it was captured.
  task automatic run_tbl(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      startFlag  = tbl[i].st;
      abort      = tbl[i].ab;
      load_done  = tbl[i].ld;
      tile_ready = tbl[i].tr;
      calc_done  = tbl[i].cd;
      if (i == 2) tile_cnt_cfg = '1;
      chk($sformatf("%s[%0d]", name, i), dut_out(), tbl[i].exp);
    end
    tbl.delete();
    @(negedge clk);
    zero_inputs();
  endtask

  // Immediate-handshake engine; optionally hammers startFlag for the whole run.
  task automatic react_run(input bit spam, output int n_done, output int n_load,
                           output int n_hs, output int n_err, output bit finished);
    bit pend;
    bit prev_lrq;
    n_done = 0; n_load = 0; n_hs = 0; n_err = 0; finished = 0;
    pend = 0; prev_lrq = 0;
    @(negedge clk);
    startFlag = 1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      startFlag  = spam ? busy : 1'b0;
      load_done  = load_req;
      tile_ready = tile_valid;
      calc_done  = pend;
      pend       = tile_valid;
      if (load_req && !prev_lrq) n_load++;
      prev_lrq = load_req;
      if (tile_valid) n_hs++;
      if (done) n_done++;
      if (err) n_err++;
      if (!busy) begin
        finished = 1;
        break;
      end
    end
    zero_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int  n_done, n_load, n_hs, n_err, n;
    bit  fin;

    rst = 0;
    zero_inputs();
    tile_cnt_cfg = '0;
    #3;
    chk("reset_async", dut_out(), pk(0, 0, 0, 0, 0, 0, 0, 0));
    #9;
    chk("reset_held", dut_out(), pk(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1;

    // Normal run, tiles {2,1,3}
    tile_cnt_cfg = {16'd3, 16'd1, 16'd2};
    add(1,0,0,0,0, 0,0, 0,0,0,0,0,0);
    add(0,0,0,0,0, 0,0, 0,0,1,0,0,0);
    add(0,0,1,0,0, 0,0, 1,0,1,0,0,0);
    add(0,0,0,1,0, 0,0, 0,1,1,0,0,0);
    add(0,0,0,0,1, 0,0, 0,0,1,0,0,0);
    add(0,0,0,1,0, 0,1, 0,1,1,0,0,0);
    add(0,0,0,0,1, 0,1, 0,0,1,0,0,0);
    add(0,0,0,0,0, 0,0, 0,0,1,0,0,0);
    add(0,0,1,0,0, 1,0, 1,0,1,0,0,0);
    add(0,0,0,1,0, 1,0, 0,1,1,0,0,0);
    add(0,0,0,0,1, 1,0, 0,0,1,0,0,0);
    add(0,0,0,0,0, 1,0, 0,0,1,0,0,0);
    add(0,0,1,0,0, 2,0, 1,0,1,0,0,0);
    add(0,0,0,1,0, 2,0, 0,1,1,0,0,0);
    add(0,0,0,0,1, 2,0, 0,0,1,0,0,0);
    add(0,0,0,1,0, 2,1, 0,1,1,0,0,0);
    add(0,0,0,0,1, 2,1, 0,0,1,0,0,0);
    add(0,0,0,1,0, 2,2, 0,1,1,0,0,0);
    add(0,0,0,0,1, 2,2, 0,0,1,0,0,0);
    add(0,0,0,0,0, 2,0, 0,0,1,0,0,0);
    add(0,0,0,0,0, 2,0, 0,0,1,1,0,0);
    add(0,0,0,0,0, 2,0, 0,0,0,0,0,0);
    run_tbl("normal");

    // Zero-tile skip, tiles {1,0,2}
    tile_cnt_cfg = {16'd2, 16'd0, 16'd1};
    add(1,0,0,0,0, 2,0, 0,0,0,0,0,0);
    add(0,0,0,0,0, 0,0, 0,0,1,0,0,0);
    add(0,0,1,0,0, 0,0, 1,0,1,0,0,0);
    add(0,0,0,1,0, 0,0, 0,1,1,0,0,0);
    add(0,0,0,0,1, 0,0, 0,0,1,0,0,0);
    add(0,0,0,0,0, 0,0, 0,0,1,0,0,0);
    add(0,0,0,0,0, 1,0, 0,0,1,0,0,0);
    add(0,0,0,0,0, 1,0, 0,0,1,0,0,0);
    add(0,0,1,0,0, 2,0, 1,0,1,0,0,0);
    add(0,0,0,1,0, 2,0, 0,1,1,0,0,0);
    add(0,0,0,0,1, 2,0, 0,0,1,0,0,0);
    add(0,0,0,1,0, 2,1, 0,1,1,0,0,0);
    add(0,0,0,0,1, 2,1, 0,0,1,0,0,0);
    add(0,0,0,0,0, 2,0, 0,0,1,0,0,0);
    add(0,0,0,0,0, 2,0, 0,0,1,1,0,0);
    add(0,0,0,0,0, 2,0, 0,0,0,0,0,0);
    run_tbl("zero_skip");

    // Backpressure on tile (0,1), tiles {2,0,0}; WAIT held two cycles before calc_done
    tile_cnt_cfg = {16'd0, 16'd0, 16'd2};
    add(1,0,0,0,0, 2,0, 0,0,0,0,0,0);
    add(0,0,0,0,0, 0,0, 0,0,1,0,0,0);
    add(0,0,1,0,0, 0,0, 1,0,1,0,0,0);
    add(0,0,0,1,0, 0,0, 0,1,1,0,0,0);
    add(0,0,0,0,1, 0,0, 0,0,1,0,0,0);
    for (int k = 0; k < 5; k++) add(0,0,0,0,0, 0,1, 0,1,1,0,0,0);
    add(0,0,0,1,0, 0,1, 0,1,1,0,0,0);
    add(0,0,0,0,0, 0,1, 0,0,1,0,0,0);
    add(0,0,0,0,1, 0,1, 0,0,1,0,0,0);
    add(0,0,0,0,0, 0,0, 0,0,1,0,0,0);
    add(0,0,0,0,0, 1,0, 0,0,1,0,0,0);
    add(0,0,0,0,0, 1,0, 0,0,1,0,0,0);
    add(0,0,0,0,0, 2,0, 0,0,1,0,0,0);
    add(0,0,0,0,0, 2,0, 0,0,1,0,0,0);
    add(0,0,0,0,0, 2,0, 0,0,1,1,0,0);
    add(0,0,0,0,0, 2,0, 0,0,0,0,0,0);
    run_tbl("backpressure");

    // Watchdog: load_done never arrives
    tile_cnt_cfg = {16'd1, 16'd1, 16'd1};
    @(negedge clk);
    startFlag = 1;
    @(negedge clk);
    startFlag = 0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!load_req) break;
      n++;
    end
    chk("timeout_load_cycles", n, TO);
    chk("timeout_err_state", dut_out(), pk(0, 0, 0, 0, 1, 0, 1, 1));
    @(negedge clk);
    chk("timeout_idle", dut_out(), pk(0, 0, 0, 0, 0, 0, 1, 1));

    tile_cnt_cfg = {16'd3, 16'd1, 16'd2};
    react_run(0, n_done, n_load, n_hs, n_err, fin);
    chk("rerun_finished", fin, 1);
    chk("rerun_done", n_done, 1);
    chk("rerun_loads", n_load, 3);
    chk("rerun_tiles", n_hs, 6);
    chk("rerun_err_seen", n_err, 0);
    chk("rerun_end", dut_out(), pk(2, 0, 0, 0, 0, 0, 0, 0));

    // Abort beats calc_done on the last tile of layer 0
    tile_cnt_cfg = {16'd1, 16'd1, 16'd1};
    add(1,0,0,0,0, 2,0, 0,0,0,0,0,0);
    add(0,0,0,0,0, 0,0, 0,0,1,0,0,0);
    add(0,0,1,0,0, 0,0, 1,0,1,0,0,0);
    add(0,0,0,1,0, 0,0, 0,1,1,0,0,0);
    add(0,1,0,0,1, 0,0, 0,0,1,0,0,0);
    add(0,0,0,0,0, 0,0, 0,0,1,0,1,2);
    add(0,0,0,0,0, 0,0, 0,0,0,0,1,2);
    add(0,0,0,0,0, 0,0, 0,0,0,0,1,2);
    run_tbl("abort");

    // calc_done in LOAD, then abort in INIT; abort/calc_done in IDLE are ignored
    add(1,0,0,0,0, 0,0, 0,0,0,0,1,2);
    add(0,0,0,0,0, 0,0, 0,0,1,0,0,0);
    add(0,0,0,0,1, 0,0, 1,0,1,0,0,0);
    add(0,0,0,0,0, 0,0, 0,0,1,0,1,3);
    add(1,0,0,0,0, 0,0, 0,0,0,0,1,3);
    add(0,1,0,0,0, 0,0, 0,0,1,0,0,0);
    add(0,0,0,0,0, 0,0, 0,0,1,0,1,2);
    add(0,1,0,0,1, 0,0, 0,0,0,0,1,2);
    add(0,0,0,0,0, 0,0, 0,0,0,0,1,2);
    run_tbl("proto");

    // Asynchronous reset in the middle of ISSUE
    tile_cnt_cfg = {16'd3, 16'd1, 16'd2};
    @(negedge clk);
    startFlag = 1;
    @(negedge clk);
    startFlag = 0;
    @(negedge clk);
    load_done = 1;
    @(negedge clk);
    load_done = 0;
    chk("pre_reset_issue", dut_out(), pk(0, 0, 0, 1, 1, 0, 0, 0));
    #2;
    rst = 0;
    #1;
    chk("mid_reset_outputs", dut_out(), pk(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1;
    chk("post_reset_idle", dut_out(), pk(0, 0, 0, 0, 0, 0, 0, 0));

    react_run(1, n_done, n_load, n_hs, n_err, fin);
    chk("spam_finished", fin, 1);
    chk("spam_done", n_done, 1);
    chk("spam_loads", n_load, 3);
    chk("spam_tiles", n_hs, 6);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (busy || done) n++;
    end
    chk("spam_stays_idle", n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
